// File: rtl/idp_dec_arb.sv
// idp_dec_arb: round-robin arbiter feeding NLANE codeword lanes
// into one shared combinational FNS decoder, one word in flight.
module idp_dec_arb #(
  parameter int NLANE = 4,
  parameter int CW    = 37,
  parameter int DW    = 26
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NLANE-1:0]           in_valid,
  input  logic [NLANE*CW-1:0]        in_code,
  output logic [NLANE-1:0]           in_ready,
  output logic [CW-1:0]              dec_codein,
  input  logic [DW-1:0]              dec_dataout,
  output logic                       out_valid,
  output logic [DW-1:0]              out_data,
  output logic [$clog2(NLANE)-1:0]   out_lane,
  input  logic                       out_ready,
  output logic                       busy
);

  localparam int LW = $clog2(NLANE);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DEC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [LW-1:0] rr_q, rr_d;
  logic [CW-1:0] cw_q, cw_d;
  logic [LW-1:0] lane_q, lane_d;
  logic          ov_q, ov_d;
  logic [DW-1:0] od_q, od_d;
  logic [LW-1:0] ol_q, ol_d;

  logic          gnt_found;
  logic [LW-1:0] gnt_idx;
  logic [LW:0]   scan;
  logic          accept;

  // First valid lane scanning upward from rr, wrapping at NLANE.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan      = '0;
    for (int k = 0; k < NLANE; k++) begin
      scan = {1'b0, rr_q} + (LW+1)'(k);
      if (scan >= (LW+1)'(NLANE)) begin
        scan = scan - (LW+1)'(NLANE);
      end
      if (!gnt_found && in_valid[scan[LW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan[LW-1:0];
      end
    end
  end

  assign accept = !rst && gnt_found &&
                  ((state_q == S_IDLE) ||
                   ((state_q == S_OUT) && out_ready));

  assign in_ready = accept ? (NLANE'(1) << gnt_idx) : '0;

  // Next-state: decode one cycle, then hold the result until taken.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cw_d    = cw_q;
    lane_d  = lane_q;
    ov_d    = ov_q;
    od_d    = od_q;
    ol_d    = ol_q;
    case (state_q)
      S_IDLE: ;
      S_DEC: begin
        od_d    = dec_dataout;
        ol_d    = lane_q;
        ov_d    = 1'b1;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      cw_d    = in_code[gnt_idx*CW +: CW];
      lane_d  = gnt_idx;
      rr_d    = (gnt_idx == LW'(NLANE-1)) ? '0 : gnt_idx + 1'b1;
      state_d = S_DEC;
    end
  end

  // State registers; reset drops any word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      cw_q    <= '0;
      lane_q  <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      ol_q    <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cw_q    <= cw_d;
      lane_q  <= lane_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      ol_q    <= ol_d;
    end
  end

  assign dec_codein = cw_q;
  assign out_valid  = ov_q;
  assign out_data   = od_q;
  assign out_lane   = ol_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_idp_dec_arb.sv
// tb_idp_dec_arb: directed and random checks of idp_dec_arb
// against a transaction-level arbitration/latency model.
module tb_idp_dec_arb;

  localparam int N  = 4;
  localparam int CW = 37;
  localparam int DW = 26;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    in_valid;
  logic [N*CW-1:0] in_code;
  logic [N-1:0]    in_ready;
  logic [CW-1:0]   dec_codein;
  logic [DW-1:0]   dec_dataout;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_lane;
  logic            out_ready;
  logic            busy;

  idp_dec_arb #(.NLANE(N), .CW(CW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_code(in_code), .in_ready(in_ready),
    .dec_codein(dec_codein), .dec_dataout(dec_dataout),
    .out_valid(out_valid), .out_data(out_data), .out_lane(out_lane),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in decoder: any fixed function with f(0)=0.
  function automatic logic [DW-1:0] fdec(input logic [CW-1:0] c);
    return c[25:0] ^ {4'b0, c[36:26], 11'b0};
  endfunction

  assign dec_dataout = fdec(dec_codein);

  int n_checks = 0;
  int n_err    = 0;

  // Model: one word in flight, age counts edges since acceptance.
  int            m_rr;
  bit            m_has;
  int            m_age;
  int            m_lane;
  logic [CW-1:0] m_code;
  logic [DW-1:0] m_data;
  logic [N-1:0]  e_rdy;
  logic          e_ov;
  int            e_g;
  bit            e_acc;

  function automatic int pick(input logic [N-1:0] v, input int rr);
    for (int k = 0; k < N; k++) begin
      if (v[(rr + k) % N]) return (rr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [CW-1:0] rcode();
    return CW'({$urandom(), $urandom()});
  endfunction

  task automatic predict();
    e_ov  = m_has && (m_age >= 1);
    e_g   = pick(in_valid, m_rr);
    e_acc = !rst && (e_g >= 0) && (!m_has || (e_ov && out_ready));
    e_rdy = e_acc ? N'(1 << e_g) : '0;
  endtask

  task automatic tick();
    predict();
    if (rst) begin
      m_has  = 0;
      m_rr   = 0;
      m_code = '0;
    end else begin
      if (e_ov && out_ready) m_has = 0;
      else if (m_has) m_age++;
      if (e_acc) begin
        m_has  = 1;
        m_age  = 0;
        m_lane = e_g;
        m_code = in_code[e_g*CW +: CW];
        m_data = fdec(m_code);
        m_rr   = (e_g + 1) % N;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
    predict();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = '0;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = '1;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) in_code[i*CW +: CW] = rcode();
    tick();
    tick();
    settle();
    n_checks++;
    if (in_ready !== 4'b0) begin
      n_err++;
      $display("FAIL reset.in_ready: got %b exp 0000", in_ready);
    end
    n_checks++;
    if ({out_valid, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL reset.valid_busy: got %b%b exp 00", out_valid, busy);
    end
    n_checks++;
    if (out_data !== '0 || out_lane !== '0) begin
      n_err++;
      $display("FAIL reset.out: got %h/%0d exp 0/0", out_data, out_lane);
    end
    n_checks++;
    if (dec_codein !== '0) begin
      n_err++;
      $display("FAIL reset.codein: got %h exp 0", dec_codein);
    end
    rst = 1'b0;
    settle();
    n_checks++;
    if (in_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL reset.first_grant: got %b exp 0001", in_ready);
    end
    tick();
  endtask

  task automatic test_rr_all();
    int gq[$];
    int lq[$];
    logic [DW-1:0] dq[$];
    int eg[5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < N; i++) in_code[i*CW +: CW] = CW'(1) << i;
    in_valid = '1;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      settle();
      n_checks++;
      if (in_ready !== e_rdy) begin
        n_err++;
        $display("FAIL rr_all.in_ready c%0d: got %b exp %b", c, in_ready, e_rdy);
      end
      n_checks++;
      if (out_valid !== e_ov) begin
        n_err++;
        $display("FAIL rr_all.out_valid c%0d: got %b exp %b", c, out_valid, e_ov);
      end
      for (int i = 0; i < N; i++) if (in_ready[i]) gq.push_back(i);
      if (out_valid && out_ready) begin
        lq.push_back(int'(out_lane));
        dq.push_back(out_data);
      end
      tick();
    end
    n_checks++;
    if (gq.size() != 5 || lq.size() != 4) begin
      n_err++;
      $display("FAIL rr_all.counts: got %0d/%0d exp 5/4", gq.size(), lq.size());
    end
    for (int i = 0; i < 5 && i < gq.size(); i++) begin
      n_checks++;
      if (gq[i] != eg[i]) begin
        n_err++;
        $display("FAIL rr_all.grant%0d: got %0d exp %0d", i, gq[i], eg[i]);
      end
    end
    for (int i = 0; i < 4 && i < lq.size(); i++) begin
      n_checks++;
      if (lq[i] != i || dq[i] !== fdec(CW'(1) << i)) begin
        n_err++;
        $display("FAIL rr_all.out%0d: got %0d/%h exp %0d/%h",
                 i, lq[i], dq[i], i, fdec(CW'(1) << i));
      end
    end
  endtask

  task automatic test_hold();
    logic [CW-1:0] c2;
    do_reset();
    in_valid = 4'b0100;
    out_ready = 1'b0;
    c2 = rcode();
    in_code[2*CW +: CW] = c2;
    settle();
    n_checks++;
    if (in_ready !== 4'b0100) begin
      n_err++;
      $display("FAIL hold.grant: got %b exp 0100", in_ready);
    end
    tick();
    for (int c = 0; c < 6; c++) begin
      in_code[2*CW +: CW] = rcode();
      settle();
      n_checks++;
      if (in_ready !== 4'b0) begin
        n_err++;
        $display("FAIL hold.in_ready c%0d: got %b exp 0000", c, in_ready);
      end
      if (c > 0) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_lane !== 2'd2 || out_data !== fdec(c2)) begin
          n_err++;
          $display("FAIL hold.out c%0d: got %b/%0d/%h exp 1/2/%h",
                   c, out_valid, out_lane, out_data, fdec(c2));
        end
      end
      tick();
    end
    out_ready = 1'b1;
    settle();
    n_checks++;
    if (in_ready !== 4'b0100 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL hold.release: got %b/%b exp 0100/1", in_ready, out_valid);
    end
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < N; i++) in_code[i*CW +: CW] = rcode();
    in_valid = 4'b0010;
    out_ready = 1'b1;
    tick();
    in_valid = 4'b0000;
    tick();
    settle();
    n_checks++;
    if (out_valid !== 1'b1 || out_lane !== 2'd1 || in_ready !== 4'b0) begin
      n_err++;
      $display("FAIL wrap.first_out: got %b/%0d/%b exp 1/1/0000",
               out_valid, out_lane, in_ready);
    end
    tick();
    in_valid = 4'b1010;
    settle();
    n_checks++;
    if (in_ready !== 4'b1000) begin
      n_err++;
      $display("FAIL wrap.grant_a: got %b exp 1000", in_ready);
    end
    tick();
    tick();
    settle();
    n_checks++;
    if (in_ready !== 4'b0010 || out_lane !== 2'd3) begin
      n_err++;
      $display("FAIL wrap.grant_b: got %b/%0d exp 0010/3", in_ready, out_lane);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [CW-1:0] cb;
    do_reset();
    in_valid = 4'b0001;
    out_ready = 1'b1;
    in_code[CW-1:0] = rcode();
    tick();
    in_code[CW-1:0] = rcode();
    tick();
    cb = rcode();
    in_code[CW-1:0] = cb;
    settle();
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL b2b.overlap: got %b/%b exp 1/0001", out_valid, in_ready);
    end
    tick();
    in_code[CW-1:0] = rcode();
    settle();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 4'b0) begin
      n_err++;
      $display("FAIL b2b.gap: got %b/%b exp 0/0000", out_valid, in_ready);
    end
    tick();
    settle();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== fdec(cb)) begin
      n_err++;
      $display("FAIL b2b.second: got %b/%h exp 1/%h", out_valid, out_data, fdec(cb));
    end
    tick();
  endtask

  task automatic test_rst_dec();
    do_reset();
    in_code[2*CW +: CW] = rcode();
    in_valid = 4'b0100;
    out_ready = 1'b1;
    tick();
    in_valid = 4'b0000;
    rst = 1'b1;
    settle();
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 4'b0) begin
      n_err++;
      $display("FAIL rst_dec.pre: got %b/%b exp 1/0000", busy, in_ready);
    end
    tick();
    rst = 1'b0;
    settle();
    n_checks++;
    if ({busy, out_valid} !== 2'b00 || dec_codein !== '0 || in_ready !== 4'b0) begin
      n_err++;
      $display("FAIL rst_dec.post: got %b%b/%h/%b exp 00/0/0000",
               busy, out_valid, dec_codein, in_ready);
    end
    tick();
    settle();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_dec.no_emit: got %b exp 0", out_valid);
    end
    in_valid = 4'b1111;
    settle();
    n_checks++;
    if (in_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL rst_dec.rr0: got %b exp 0001", in_ready);
    end
    tick();
  endtask

  task automatic test_codes();
    do_reset();
    in_valid = 4'b0001;
    out_ready = 1'b1;
    in_code[CW-1:0] = '0;
    tick();
    tick();
    in_code[CW-1:0] = CW'(1) << 36;
    settle();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 26'h0) begin
      n_err++;
      $display("FAIL codes.zero: got %b/%h exp 1/0", out_valid, out_data);
    end
    tick();
    tick();
    settle();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 26'h200000) begin
      n_err++;
      $display("FAIL codes.bit36: got %b/%h exp 1/200000", out_valid, out_data);
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      in_valid = N'($urandom());
      for (int i = 0; i < N; i++) in_code[i*CW +: CW] = rcode();
      out_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 49) == 0);
      settle();
      n_checks++;
      if (in_ready !== e_rdy || out_valid !== e_ov || busy !== m_has) begin
        n_err++;
        $display("FAIL random.ctl c%0d: got %b/%b/%b exp %b/%b/%b",
                 c, in_ready, out_valid, busy, e_rdy, e_ov, m_has);
      end
      n_checks++;
      if (dec_codein !== m_code) begin
        n_err++;
        $display("FAIL random.codein c%0d: got %h exp %h", c, dec_codein, m_code);
      end
      if (e_ov) begin
        n_checks++;
        if (out_data !== m_data || int'(out_lane) != m_lane) begin
          n_err++;
          $display("FAIL random.out c%0d: got %h/%0d exp %h/%0d",
                   c, out_data, out_lane, m_data, m_lane);
        end
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = '0;
    in_code = '0;
    out_ready = 1'b0;
    m_rr = 0;
    m_has = 0;
    m_age = 0;
    m_lane = 0;
    m_code = '0;
    m_data = '0;
    test_reset();
    test_rr_all();
    test_hold();
    test_wrap();
    test_back_to_back();
    test_rst_dec();
    test_codes();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
